// File: rtl/alu_mult_sequencer.sv
// Shift-and-add N x N -> 2N multiplier that drives an external combinational ALU.
// Optional SIGNED_MULT_EN: two's-complement operands via magnitude multiply plus a two-pass negate.
module alu_mult_sequencer #(
    parameter int N = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic           alu_c_o,
    output logic           alu_invert_o,
    output logic           alu_less_o,
    output logic [2:0]     alu_operacion_o,
    input  logic [N-1:0]   alu_resultado_i,
    input  logic           alu_c_i
);
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DONE   = 3'd2
`ifdef SIGNED_MULT_EN
        ,
        NEG_LO = 3'd3,
        NEG_HI = 3'd4
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    p_hi_q, p_hi_d;
    logic [N-1:0]    p_lo_q, p_lo_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  product_q, product_d;
    logic [N-1:0]    a_mag, b_mag;
    logic            last_pass;

`ifdef SIGNED_MULT_EN
    logic neg_q, neg_d;
    logic carry_q, carry_d;

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign a_mag = a_i[N-1] ? (~a_i + N'(1)) : a_i;
    assign b_mag = b_i[N-1] ? (~b_i + N'(1)) : b_i;
`else
    assign a_mag = a_i;
    assign b_mag = b_i;
`endif

    assign last_pass = (count_q == CW'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
`ifdef SIGNED_MULT_EN
            neg_q     <= 1'b0;
            carry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            product_q <= product_d;
`ifdef SIGNED_MULT_EN
            neg_q     <= neg_d;
            carry_q   <= carry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        p_hi_d       = p_hi_q;
        p_lo_d       = p_lo_q;
        mcand_d      = mcand_q;
        count_d      = count_q;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_c_o      = 1'b0;
        alu_invert_o = 1'b0;
`ifdef SIGNED_MULT_EN
        neg_d        = neg_q;
        carry_d      = carry_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d = a_mag;
                    p_lo_d  = b_mag;
                    p_hi_d  = '0;
                    count_d = '0;
`ifdef SIGNED_MULT_EN
                    neg_d   = a_i[N-1] ^ b_i[N-1];
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a_o = p_hi_q;
                alu_b_o = p_lo_q[0] ? mcand_q : '0;
                // ALU carry-out becomes the new top bit so no partial-sum bit is dropped.
                {p_hi_d, p_lo_d} = {alu_c_i, alu_resultado_i, p_lo_q[N-1:1]};
                count_d = count_q + CW'(1);
                if (last_pass) begin
`ifdef SIGNED_MULT_EN
                    state_d = neg_q ? NEG_LO : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SIGNED_MULT_EN
            NEG_LO: begin
                alu_b_o      = p_lo_q;
                alu_invert_o = 1'b1;
                alu_c_o      = 1'b1;
                p_lo_d       = alu_resultado_i;
                carry_d      = alu_c_i;
                state_d      = NEG_HI;
            end
            NEG_HI: begin
                alu_b_o      = p_hi_q;
                alu_invert_o = 1'b1;
                alu_c_o      = carry_q;
                p_hi_d       = alu_resultado_i;
                state_d      = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product_d = (state_d == DONE && state_q != DONE) ? {p_hi_d, p_lo_d} : product_q;

    assign busy_o          = (state_q != IDLE) && (state_q != DONE);
    assign done_o          = (state_q == DONE);
    assign product_o       = product_q;
    assign alu_less_o      = 1'b0;
    assign alu_operacion_o = 3'b010;
endmodule
